// File: rtl/rgb_led_pwm_if.sv
// Configuration write channel of the RGB LED PWM controller.
// The controller side uses the slave modport; the control logic drives the master modport.
interface rgb_led_pwm_if #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned RATE_BITS = 8
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [1:0]           cfg_mode;
  logic [PWM_BITS-1:0]  cfg_duty;
  logic [RATE_BITS-1:0] cfg_rate;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
    output cfg_ready
  );
endinterface

// File: rtl/rgb_led_pwm.sv
// N-channel PWM LED controller with off/solid/blink/breathe modes.
// Writes land in shadow registers and are applied only at frame boundaries.
module rgb_led_pwm #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned PRESCALE  = 188,
  parameter int unsigned RATE_BITS = 8
) (
  input  logic              clk_48m,
  input  logic              reset_n,
  rgb_led_pwm_if.slave      cfg_bus,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {ModeOff, ModeSolid, ModeBlink, ModeBreathe} mode_e;

  logic [PS_W-1:0]     presc_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                tick;
  logic                boundary;
  logic                wr;

  mode_e                act_mode_q  [NUM_CH];
  logic [PWM_BITS-1:0]  act_duty_q  [NUM_CH];
  logic [RATE_BITS-1:0] act_rate_q  [NUM_CH];
  mode_e                shd_mode_q  [NUM_CH];
  logic [PWM_BITS-1:0]  shd_duty_q  [NUM_CH];
  logic [RATE_BITS-1:0] shd_rate_q  [NUM_CH];
  logic [RATE_BITS-1:0] div_q       [NUM_CH];
  logic [PWM_BITS-1:0]  level_q     [NUM_CH];
  logic [NUM_CH-1:0]    pending_q;
  logic [NUM_CH-1:0]    phase_q;
  logic [NUM_CH-1:0]    dir_down_q;

  function automatic logic cmp(input logic [PWM_BITS-1:0] x, input logic [PWM_BITS-1:0] cnt);
    return (x == {PWM_BITS{1'b1}}) ? 1'b1 : (cnt < x);
  endfunction

  function automatic logic [RATE_BITS-1:0] reff(input logic [RATE_BITS-1:0] r);
    return (r == '0) ? RATE_BITS'(1) : r;
  endfunction

  always_comb begin
    tick              = (presc_q == PS_W'(PRESCALE - 1));
    boundary          = tick && (pwm_cnt_q == {PWM_BITS{1'b1}});
    // Out-of-range channels stay ready so their writes are swallowed.
    cfg_bus.cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_bus.cfg_ch == CH_W'(i)) cfg_bus.cfg_ready = ~pending_q[i];
    end
    wr = cfg_bus.cfg_valid && cfg_bus.cfg_ready;
  end

  always_ff @(posedge clk_48m) begin
    if (!reset_n) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      frame_start <= 1'b0;
      pwm_out     <= '0;
      pending_q   <= '0;
      phase_q     <= '0;
      dir_down_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        act_mode_q[i] <= ModeOff;
        act_duty_q[i] <= '0;
        act_rate_q[i] <= '0;
        shd_mode_q[i] <= ModeOff;
        shd_duty_q[i] <= '0;
        shd_rate_q[i] <= '0;
        div_q[i]      <= '0;
        level_q[i]    <= '0;
      end
    end else begin
      presc_q     <= tick ? '0 : presc_q + 1'b1;
      frame_start <= boundary;
      if (tick) pwm_cnt_q <= pwm_cnt_q + 1'b1;

      for (int i = 0; i < NUM_CH; i++) begin
        unique case (act_mode_q[i])
          ModeOff:     pwm_out[i] <= 1'b0;
          ModeSolid:   pwm_out[i] <= cmp(act_duty_q[i], pwm_cnt_q);
          ModeBlink:   pwm_out[i] <= phase_q[i] && cmp(act_duty_q[i], pwm_cnt_q);
          ModeBreathe: pwm_out[i] <= cmp(level_q[i], pwm_cnt_q);
        endcase

        if (boundary) begin
          if (pending_q[i]) begin
            act_mode_q[i] <= shd_mode_q[i];
            act_duty_q[i] <= shd_duty_q[i];
            act_rate_q[i] <= shd_rate_q[i];
            pending_q[i]  <= 1'b0;
            div_q[i]      <= '0;
            phase_q[i]    <= 1'b1;
            level_q[i]    <= '0;
            dir_down_q[i] <= 1'b0;
          end else if (div_q[i] == reff(act_rate_q[i]) - 1'b1) begin
            div_q[i] <= '0;
            if (act_mode_q[i] == ModeBlink) phase_q[i] <= ~phase_q[i];
            if (act_mode_q[i] == ModeBreathe) begin
              // Peak and floor each hold for one extra step while direction flips.
              if (!dir_down_q[i]) begin
                if (level_q[i] < act_duty_q[i]) level_q[i] <= level_q[i] + 1'b1;
                else                            dir_down_q[i] <= 1'b1;
              end else begin
                if (level_q[i] != '0) level_q[i] <= level_q[i] - 1'b1;
                else                  dir_down_q[i] <= 1'b0;
              end
            end
          end else begin
            div_q[i] <= div_q[i] + 1'b1;
          end
        end

        // A write in the boundary cycle overrides the pending clear above.
        if (wr && (cfg_bus.cfg_ch == CH_W'(i))) begin
          shd_mode_q[i] <= mode_e'(cfg_bus.cfg_mode);
          shd_duty_q[i] <= cfg_bus.cfg_duty;
          shd_rate_q[i] <= cfg_bus.cfg_rate;
          pending_q[i]  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed bench for rgb_led_pwm: 4-bit PWM, prescale 2, three channels (32-cycle frames).
module tb_rgb_led_pwm;
  logic       clk_48m = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] pwm_out;
  logic       frame_start;
  int         total = 0;
  int         bad   = 0;

  rgb_led_pwm_if #(.NUM_CH(3), .PWM_BITS(4), .RATE_BITS(8)) cfg_if ();

  rgb_led_pwm #(.NUM_CH(3), .PWM_BITS(4), .PRESCALE(2), .RATE_BITS(8)) dut (
    .clk_48m     (clk_48m),
    .reset_n     (reset_n),
    .cfg_bus     (cfg_if.slave),
    .pwm_out     (pwm_out),
    .frame_start (frame_start)
  );

  always #5 clk_48m = ~clk_48m;

  task automatic write_cfg(input int ch, input int mode, input int duty, input int rate);
    @(negedge clk_48m);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_mode  = 2'(mode);
    cfg_if.cfg_duty  = 4'(duty);
    cfg_if.cfg_rate  = 8'(rate);
    @(negedge clk_48m);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    @(negedge clk_48m);
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk_48m);
      n++;
    end
    total++;
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL %s: frame_start timeout got %b expected 1", name, frame_start);
    end
  endtask

  // Counts high cycles per channel over one frame starting at a frame_start sample.
  task automatic measure(output int h0, output int h1, output int h2);
    h0 = 0; h1 = 0; h2 = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_48m);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_duty  = '0;
    cfg_if.cfg_rate  = '0;
    reset_n = 1'b0;
    repeat (5) @(negedge clk_48m);
    reset_n = 1'b1;
    total += 3;
    if (pwm_out !== 3'b000) begin
      bad++; $display("FAIL reset_pwm: got %b expected 000", pwm_out);
    end
    if (cfg_if.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready);
    end
    if (frame_start !== 1'b0) begin
      bad++; $display("FAIL reset_fs: got %b expected 0", frame_start);
    end
    do begin
      @(negedge clk_48m);
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    total++;
    if (n != 32) begin
      bad++; $display("FAIL reset_first_fs: got %0d cycles expected 32", n);
    end
  endtask

  task automatic test_solid();
    int h0, h1, h2;
    int duties [3] = '{4, 15, 0};
    int exp    [3] = '{8, 32, 0};
    for (int d = 0; d < 3; d++) begin
      write_cfg(0, 1, duties[d], 0);
      wait_fs("solid_apply");
      for (int f = 0; f < 2; f++) begin
        measure(h0, h1, h2);
        total++;
        if (h0 !== exp[d]) begin
          bad++; $display("FAIL solid_duty%0d: got %0d high cycles expected %0d", duties[d], h0, exp[d]);
        end
      end
    end
  endtask

  task automatic test_handshake();
    int h0, h1, h2;
    write_cfg(1, 1, 15, 0);
    cfg_if.cfg_ch = 2'd1;
    #1;
    total++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      bad++; $display("FAIL hs_pending_ch1: got %b expected 0", cfg_if.cfg_ready);
    end
    cfg_if.cfg_ch = 2'd2;
    #1;
    total++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL hs_ready_ch2: got %b expected 1", cfg_if.cfg_ready);
    end
    write_cfg(2, 1, 8, 0);
    cfg_if.cfg_ch = 2'd3;
    #1;
    total++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL hs_ready_ch3: got %b expected 1", cfg_if.cfg_ready);
    end
    write_cfg(3, 1, 15, 0);
    wait_fs("hs_apply");
    cfg_if.cfg_ch = 2'd1;
    #1;
    total++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL hs_ready_after_fs: got %b expected 1", cfg_if.cfg_ready);
    end
    measure(h0, h1, h2);
    total += 3;
    if (h0 !== 0)  begin bad++; $display("FAIL hs_ch0_untouched: got %0d expected 0", h0); end
    if (h1 !== 32) begin bad++; $display("FAIL hs_ch1: got %0d expected 32", h1); end
    if (h2 !== 16) begin bad++; $display("FAIL hs_ch2: got %0d expected 16", h2); end

    // Land a write exactly on the boundary edge.
    repeat (31) @(negedge clk_48m);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd1;
    cfg_if.cfg_mode  = 2'd1;
    cfg_if.cfg_duty  = 4'd0;
    cfg_if.cfg_rate  = 8'd0;
    @(negedge clk_48m);
    cfg_if.cfg_valid = 1'b0;
    #1;
    total += 2;
    if (frame_start !== 1'b1) begin
      bad++; $display("FAIL hs_bnd_fs: got %b expected 1", frame_start);
    end
    if (cfg_if.cfg_ready !== 1'b0) begin
      bad++; $display("FAIL hs_bnd_pending: got %b expected 0", cfg_if.cfg_ready);
    end
    measure(h0, h1, h2);
    total++;
    if (h1 !== 32) begin bad++; $display("FAIL hs_bnd_old: got %0d expected 32", h1); end
    measure(h0, h1, h2);
    total++;
    if (h1 !== 0) begin bad++; $display("FAIL hs_bnd_new: got %0d expected 0", h1); end
  endtask

  task automatic test_blink();
    int h0, h1, h2;
    int exp2 [5] = '{32, 32, 0, 0, 32};
    int exp0 [4] = '{32, 0, 32, 0};
    write_cfg(2, 2, 15, 2);
    wait_fs("blink2_apply");
    for (int f = 0; f < 5; f++) begin
      measure(h0, h1, h2);
      total++;
      if (h2 !== exp2[f]) begin
        bad++; $display("FAIL blink_rate2_f%0d: got %0d expected %0d", f, h2, exp2[f]);
      end
    end
    write_cfg(2, 2, 15, 0);
    wait_fs("blink0_apply");
    for (int f = 0; f < 4; f++) begin
      measure(h0, h1, h2);
      total++;
      if (h2 !== exp0[f]) begin
        bad++; $display("FAIL blink_rate0_f%0d: got %0d expected %0d", f, h2, exp0[f]);
      end
    end
  endtask

  task automatic test_breathe();
    int h0, h1, h2;
    int exp [10] = '{0, 2, 4, 6, 6, 4, 2, 0, 0, 2};
    write_cfg(0, 3, 3, 1);
    wait_fs("breathe_apply");
    for (int f = 0; f < 10; f++) begin
      measure(h0, h1, h2);
      total++;
      if (h0 !== exp[f]) begin
        bad++; $display("FAIL breathe_f%0d: got %0d expected %0d", f, h0, exp[f]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int h0, h1, h2;
    write_cfg(2, 1, 15, 0);
    wait_fs("midrst_apply");
    repeat (4) @(negedge clk_48m);
    total++;
    if (pwm_out[2] !== 1'b1) begin
      bad++; $display("FAIL midrst_pre_on: got %b expected 1", pwm_out[2]);
    end
    write_cfg(1, 1, 15, 0);
    reset_n = 1'b0;
    @(negedge clk_48m);
    cfg_if.cfg_ch = 2'd1;
    #1;
    total += 3;
    if (pwm_out !== 3'b000) begin
      bad++; $display("FAIL midrst_pwm: got %b expected 000", pwm_out);
    end
    if (frame_start !== 1'b0) begin
      bad++; $display("FAIL midrst_fs: got %b expected 0", frame_start);
    end
    if (cfg_if.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_ready: got %b expected 1", cfg_if.cfg_ready);
    end
    repeat (3) @(negedge clk_48m);
    reset_n = 1'b1;
    wait_fs("midrst_fs");
    for (int f = 0; f < 2; f++) begin
      measure(h0, h1, h2);
      total++;
      if ((h0 + h1 + h2) !== 0) begin
        bad++; $display("FAIL midrst_off_f%0d: got %0d/%0d/%0d expected 0/0/0", f, h0, h1, h2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_handshake();
    test_blink();
    test_breathe();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
